// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI transmitter and receiver:
//               state encodings for both ends and default frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default word length (bits) and sclk half-period (clk_in cycles)
    localparam int c_spi_count_default = 8;
    localparam int c_clk_div_default   = 4;

    // Transmitter state encoding; values 5..7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_SETUP = 3'd1,
        TX_SHIFT = 3'd2,
        TX_HOLD  = 3'd3,
        TX_DONE  = 3'd4
    } tx_state_t;

    // Receiver state encoding, kept here so both ends share one definition
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_DONE  = 2'd2,
        RX_ERROR = 2'd3
    } rx_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : sclk divider. Runs only while the transmitter is in SHIFT and
//               is cleared whenever it is not, so every SHIFT entry starts a
//               fresh bit period. Provides the registered sclk level plus
//               half-period and bit-period ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = c_clk_div_default
) (
    input  logic clk_in,
    input  logic reset,
    input  logic i_enable,    // transmitter is in SHIFT this cycle
    input  logic i_run_next,  // transmitter will be in SHIFT next cycle
    output logic o_sclk,
    output logic o_half_tick,
    output logic o_bit_tick
);

    localparam int              DW         = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0]   c_div_last = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic [DW-1:0] w_div_cnt_d;
    logic          r_phase;      // 0: sclk-high half, 1: sclk-low half
    logic          w_phase_d;
    logic          r_sclk;

    // Divider next-state: wrap at CLK_DIV-1 and flip the half-period phase
    always_comb begin
        o_half_tick = i_enable && (r_div_cnt == c_div_last);
        o_bit_tick  = o_half_tick && r_phase;
        w_div_cnt_d = '0;
        w_phase_d   = 1'b0;
        if (i_enable) begin
            if (o_half_tick) begin
                w_div_cnt_d = '0;
                w_phase_d   = ~r_phase;
            end else begin
                w_div_cnt_d = r_div_cnt + DW'(1);
                w_phase_d   = r_phase;
            end
        end
    end

    // Divider registers; sclk is registered from the phase it will have next
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
            r_sclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_cnt_d;
            r_phase   <= w_phase_d;
            r_sclk    <= i_run_next && !w_phase_d;
        end
    end

    assign o_sclk = r_sclk;

endmodule : spi_sclk_gen
`default_nettype wire

// File: rtl/spi_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_piso_tx
// Description : SPI transmitter. Captures a parallel word on start and shifts
//               it out MSB-first with self-generated sclk and active-low
//               latch. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_piso_tx
    import spi_pkg::*;
#(
    parameter int SPI_COUNT = c_spi_count_default,
    parameter int CLK_DIV   = c_clk_div_default
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SPI_COUNT-1:0] pi,
    input  logic                 abort,
    output logic                 sclk,
    output logic                 latch,
    output logic                 so,
    output logic                 busy,
    output logic                 trans_done,
    output logic                 aborted
);

    localparam int            DW          = $clog2(CLK_DIV) + 1;
    localparam int            BW          = $clog2(SPI_COUNT) + 1;
    localparam logic [DW-1:0] c_div_last  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] c_bit_last  = BW'(SPI_COUNT - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_d;
    logic [DW-1:0]        r_wait_cnt;   // SETUP / HOLD duration counter
    logic [DW-1:0]        w_wait_d;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_bit_d;
    logic [SPI_COUNT-1:0] r_shreg;
    logic [SPI_COUNT-1:0] w_shreg_d;
    logic                 w_abort_hit;
    logic                 w_frame_d;
    logic                 w_in_shift;
    logic                 w_shift_next;
    logic                 w_half_tick;
    logic                 w_bit_tick;
    logic                 w_bit_evt;

    assign w_in_shift   = (r_state == TX_SHIFT);
    assign w_shift_next = (w_state_d == TX_SHIFT);
    // bit_tick is only meaningful on a divider wrap, so qualify it with one
    assign w_bit_evt    = w_half_tick && w_bit_tick;

    spi_sclk_gen #(
        .CLK_DIV     (CLK_DIV)
    ) u_sclk_gen (
        .clk_in      (clk_in),
        .reset       (reset),
        .i_enable    (w_in_shift),
        .i_run_next  (w_shift_next),
        .o_sclk      (sclk),
        .o_half_tick (w_half_tick),
        .o_bit_tick  (w_bit_tick)
    );

    // Frame sequencing: next state, counters and shift register
    always_comb begin
        w_state_d   = r_state;
        w_wait_d    = r_wait_cnt;
        w_bit_d     = r_bit_cnt;
        w_shreg_d   = r_shreg;
        w_abort_hit = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_wait_d = '0;
                w_bit_d  = '0;
                if (start) begin
                    w_state_d = TX_SETUP;
                    w_shreg_d = pi;
                end
            end
            TX_SETUP: begin
                if (abort) begin
                    w_state_d   = TX_IDLE;
                    w_abort_hit = 1'b1;
                    w_wait_d    = '0;
                end else if (r_wait_cnt == c_div_last) begin
                    w_state_d = TX_SHIFT;
                    w_wait_d  = '0;
                end else begin
                    w_wait_d = r_wait_cnt + DW'(1);
                end
            end
            TX_SHIFT: begin
                if (abort) begin
                    w_state_d   = TX_IDLE;
                    w_abort_hit = 1'b1;
                    w_bit_d     = '0;
                end else if (w_bit_evt) begin
                    if (r_bit_cnt == c_bit_last) begin
                        // Last bit: keep the register so so holds it in HOLD
                        w_state_d = TX_HOLD;
                        w_bit_d   = '0;
                    end else begin
                        w_bit_d   = r_bit_cnt + BW'(1);
                        w_shreg_d = {r_shreg[SPI_COUNT-2:0], 1'b0};
                    end
                end
            end
            TX_HOLD: begin
                if (abort) begin
                    w_state_d   = TX_IDLE;
                    w_abort_hit = 1'b1;
                    w_wait_d    = '0;
                end else if (r_wait_cnt == c_div_last) begin
                    w_state_d = TX_DONE;
                    w_wait_d  = '0;
                end else begin
                    w_wait_d = r_wait_cnt + DW'(1);
                end
            end
            TX_DONE: begin
                w_state_d = TX_IDLE;
            end
            default: begin
                w_state_d = TX_IDLE;
                w_wait_d  = '0;
                w_bit_d   = '0;
            end
        endcase
        w_frame_d = (w_state_d == TX_SETUP) || (w_state_d == TX_SHIFT) ||
                    (w_state_d == TX_HOLD);
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= TX_IDLE;
            r_wait_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            latch      <= 1'b1;
            so         <= 1'b0;
            busy       <= 1'b0;
            trans_done <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_d;
            r_bit_cnt  <= w_bit_d;
            r_shreg    <= w_shreg_d;
            latch      <= !w_frame_d;
            so         <= w_frame_d && w_shreg_d[SPI_COUNT-1];
            busy       <= (w_state_d != TX_IDLE);
            trans_done <= (w_state_d == TX_DONE);
            aborted    <= w_abort_hit;
        end
    end

endmodule : spi_piso_tx
`default_nettype wire

// File: tb/tb_spi_piso_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_piso_tx
// Description : Self-checking bench for spi_piso_tx. Two instances (CLK_DIV=4
//               and CLK_DIV=1) are compared cycle by cycle against a waveform
//               model computed from the frame timing rules, with a simple
//               behavioural receiver watching the CLK_DIV=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_piso_tx;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       start0, abort0, start1, abort1;
    logic [7:0] pi0, pi1;
    logic       sclk0, latch0, so0, busy0, tdone0, abrt0;
    logic       sclk1, latch1, so1, busy1, tdone1, abrt1;
    logic [5:0] obs0, obs1;

    int total = 0;
    int bad   = 0;

    // {latch, sclk, so, busy, trans_done, aborted}
    localparam logic [5:0] IDLE_V  = 6'b100000;
    localparam logic [5:0] ABORT_V = 6'b100001;

    always #5 clk_in = ~clk_in;

    spi_piso_tx #(.SPI_COUNT(8), .CLK_DIV(4)) dut0 (
        .clk_in(clk_in), .reset(reset), .start(start0), .pi(pi0), .abort(abort0),
        .sclk(sclk0), .latch(latch0), .so(so0), .busy(busy0),
        .trans_done(tdone0), .aborted(abrt0)
    );

    spi_piso_tx #(.SPI_COUNT(8), .CLK_DIV(1)) dut1 (
        .clk_in(clk_in), .reset(reset), .start(start1), .pi(pi1), .abort(abort1),
        .sclk(sclk1), .latch(latch1), .so(so1), .busy(busy1),
        .trans_done(tdone1), .aborted(abrt1)
    );

    assign obs0 = {latch0, sclk0, so0, busy0, tdone0, abrt0};
    assign obs1 = {latch1, sclk1, so1, busy1, tdone1, abrt1};

    // Expected outputs in cycle k after the start edge (k >= 1), 8-bit word.
    // Latch-low window = d setup + 8 bits of 2d + d hold; then one DONE cycle.
    function automatic logic [5:0] model(int k, int d, logic [7:0] w);
        int t;
        int b;
        logic hi;
        if (k >= 1 && k <= d * 18) begin
            t = k - 1;
            if (t < d) return {1'b0, 1'b0, w[7], 1'b1, 1'b0, 1'b0};
            t = t - d;
            if (t < 16 * d) begin
                b  = t / (2 * d);
                hi = (t % (2 * d)) < d;
                return {1'b0, hi, w[7 - b], 1'b1, 1'b0, 1'b0};
            end
            return {1'b0, 1'b0, w[0], 1'b1, 1'b0, 1'b0};
        end
        if (k == d * 18 + 1) return 6'b100110;
        return IDLE_V;
    endfunction

    // Behavioural receiver on dut0: samples so at sclk falling edges
    logic [7:0] rx_po;
    int         rx_cnt;
    logic       rx_err, rx_done, prev_l, prev_s;
    always @(negedge clk_in) begin
        if (reset) begin
            rx_po <= '0; rx_cnt <= 0; rx_err <= 1'b0; rx_done <= 1'b0;
            prev_l <= 1'b1; prev_s <= 1'b0;
        end else begin
            prev_l <= latch0;
            prev_s <= sclk0;
            if (prev_l && !latch0) begin
                rx_cnt <= 0; rx_err <= 1'b0; rx_done <= 1'b0;
            end else if (!latch0 && prev_s && !sclk0) begin
                rx_po  <= {rx_po[6:0], so0};
                rx_cnt <= rx_cnt + 1;
            end
            if (!prev_l && latch0) begin
                if (tdone0 && rx_cnt == 8) rx_done <= 1'b1;
                else                       rx_err  <= 1'b1;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        start0 = 0; abort0 = 0; pi0 = '0;
        start1 = 0; abort1 = 0; pi1 = '0;
        #1 reset = 1'b1;
        #1;
        total++;
        if (obs0 !== IDLE_V) begin bad++; $display("FAIL reset_async0 got=%b exp=%b", obs0, IDLE_V); end
        total++;
        if (obs1 !== IDLE_V) begin bad++; $display("FAIL reset_async1 got=%b exp=%b", obs1, IDLE_V); end
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        total++;
        if (obs0 !== IDLE_V) begin bad++; $display("FAIL reset_idle got=%b exp=%b", obs0, IDLE_V); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] w;
        logic [5:0] e;
        int rises = 0, low = 0, dones = 0;
        logic ps = 1'b0;
        w = 8'hA5;
        pi0 = w; start0 = 1;
        @(negedge clk_in); start0 = 0;
        for (int k = 1; k <= 75; k++) begin
            e = model(k, 4, w);
            total++;
            if (obs0 !== e) begin bad++; $display("FAIL basic cyc=%0d got=%b exp=%b", k, obs0, e); end
            if (sclk0 && !ps) rises++;
            ps = sclk0;
            if (!latch0) low++;
            if (tdone0) dones++;
            @(negedge clk_in);
        end
        total++;
        if (rises != 8) begin bad++; $display("FAIL basic_rises got=%0d exp=8", rises); end
        total++;
        if (low != 72) begin bad++; $display("FAIL basic_latch_low got=%0d exp=72", low); end
        total++;
        if (dones != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", dones); end
    endtask

    task automatic test_random_frames();
        logic [7:0] w;
        logic [5:0] e;
        for (int f = 0; f < 4; f++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            pi0 = w; start0 = 1;
            @(negedge clk_in); start0 = 0;
            for (int k = 1; k <= 74; k++) begin
                e = model(k, 4, w);
                total++;
                if (obs0 !== e) begin bad++; $display("FAIL rand w=%h cyc=%0d got=%b exp=%b", w, k, obs0, e); end
                pi0 = 8'($urandom);
                @(negedge clk_in);
            end
        end
    endtask

    task automatic test_loopback();
        logic [5:0] e;
        pi0 = 8'h3C; start0 = 1;
        @(negedge clk_in); start0 = 0;
        for (int k = 1; k <= 76; k++) begin
            e = model(k, 4, 8'h3C);
            total++;
            if (obs0 !== e) begin bad++; $display("FAIL loop cyc=%0d got=%b exp=%b", k, obs0, e); end
            @(negedge clk_in);
        end
        total++;
        if (rx_po !== 8'h3C) begin bad++; $display("FAIL loop_po got=%h exp=3c", rx_po); end
        total++;
        if (rx_done !== 1'b1 || rx_err !== 1'b0) begin
            bad++; $display("FAIL loop_flags done=%b err=%b exp done=1 err=0", rx_done, rx_err);
        end
    endtask

    task automatic test_start_while_busy();
        logic [5:0] e;
        pi0 = 8'h81; start0 = 1;
        @(negedge clk_in); start0 = 0;
        for (int k = 1; k <= 82; k++) begin
            e = model(k, 4, 8'h81);
            total++;
            if (obs0 !== e) begin bad++; $display("FAIL busy_start cyc=%0d got=%b exp=%b", k, obs0, e); end
            start0 = (k == 20);
            if (k == 20) pi0 = 8'hFF;
            @(negedge clk_in);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1, w2;
        logic [5:0] e;
        int hi_gap = 0;
        w1 = 8'($urandom); w2 = 8'($urandom);
        pi0 = w1; start0 = 1;
        @(negedge clk_in);
        pi0 = w2;
        for (int k = 1; k <= 150; k++) begin
            e = (k <= 74) ? model(k, 4, w1) : model(k - 74, 4, w2);
            total++;
            if (obs0 !== e) begin bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", k, obs0, e); end
            if (k >= 60 && k <= 100 && latch0) hi_gap++;
            if (k == 80) start0 = 0;
            @(negedge clk_in);
        end
        total++;
        if (hi_gap != 2) begin bad++; $display("FAIL b2b_latch_gap got=%0d exp=2", hi_gap); end
    endtask

    task automatic test_abort();
        logic [7:0] w;
        logic [5:0] e;
        int ka, dones;
        // Abort after the 3rd sclk rising edge, then at a random frame cycle
        for (int pass = 0; pass < 2; pass++) begin
            w  = 8'($urandom);
            ka = (pass == 0) ? (4 + 2 * 8 + 1) : $urandom_range(1, 72);
            dones = 0;
            pi0 = w; start0 = 1;
            @(negedge clk_in); start0 = 0;
            for (int k = 1; k <= ka + 4; k++) begin
                e = (k <= ka) ? model(k, 4, w) : ((k == ka + 1) ? ABORT_V : IDLE_V);
                total++;
                if (obs0 !== e) begin bad++; $display("FAIL abort%0d ka=%0d cyc=%0d got=%b exp=%b", pass, ka, k, obs0, e); end
                if (tdone0) dones++;
                abort0 = (k == ka);
                @(negedge clk_in);
            end
            total++;
            if (dones != 0 || rx_err !== 1'b1) begin
                bad++; $display("FAIL abort%0d_side dones=%0d rx_err=%b exp 0 and 1", pass, dones, rx_err);
            end
        end
        // start wins over abort in IDLE; abort in DONE and IDLE is ignored
        w = 8'($urandom);
        pi0 = w; start0 = 1; abort0 = 1;
        @(negedge clk_in); start0 = 0; abort0 = 0;
        for (int k = 1; k <= 76; k++) begin
            e = model(k, 4, w);
            total++;
            if (obs0 !== e) begin bad++; $display("FAIL abort_ignored cyc=%0d got=%b exp=%b", k, obs0, e); end
            abort0 = (k >= 73 && k <= 75);
            @(negedge clk_in);
        end
        abort0 = 0;
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        logic [5:0] e;
        w = 8'($urandom);
        pi0 = w; start0 = 1;
        @(negedge clk_in); start0 = 0;
        for (int k = 1; k <= 30; k++) begin
            e = model(k, 4, w);
            total++;
            if (obs0 !== e) begin bad++; $display("FAIL pre_reset cyc=%0d got=%b exp=%b", k, obs0, e); end
            if (k < 30) @(negedge clk_in);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs0 !== IDLE_V) begin bad++; $display("FAIL reset_mid_frame got=%b exp=%b", obs0, IDLE_V); end
        @(negedge clk_in);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            total++;
            if (obs0 !== IDLE_V) begin bad++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", k, obs0, IDLE_V); end
        end
        w = 8'($urandom);
        pi0 = w; start0 = 1;
        @(negedge clk_in); start0 = 0;
        for (int k = 1; k <= 75; k++) begin
            e = model(k, 4, w);
            total++;
            if (obs0 !== e) begin bad++; $display("FAIL after_reset cyc=%0d got=%b exp=%b", k, obs0, e); end
            @(negedge clk_in);
        end
    endtask

    task automatic test_clkdiv1();
        logic [7:0] w;
        logic [5:0] e;
        int low;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 8'h00 : 8'hFF;
            low = 0;
            pi1 = w; start1 = 1;
            @(negedge clk_in); start1 = 0;
            for (int k = 1; k <= 21; k++) begin
                e = model(k, 1, w);
                total++;
                if (obs1 !== e) begin bad++; $display("FAIL div1 w=%h cyc=%0d got=%b exp=%b", w, k, obs1, e); end
                if (!latch1) low++;
                @(negedge clk_in);
            end
            total++;
            if (low != 18) begin bad++; $display("FAIL div1_latch_low w=%h got=%0d exp=18", w, low); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_random_frames();
        test_loopback();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_clkdiv1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_piso_tx
`default_nettype wire
